// File: rtl/line_drawer.sv
// line_drawer: Bresenham line rasterizer for the 640x480 1-bit framebuffer.
//
// Accepts one line request (two endpoints plus a colour) while idle. It waits
// for the upstream clear stage to report done, then emits one pixel write per
// cycle in ascending major-axis order, followed by a one-cycle done pulse.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               request strobe, sampled only while idle
//   x0, y0, x1, y1      endpoints, latched on the accepting edge
//   color_in            line colour, latched with the endpoints
//   clear_done          clear-stage done; drawing is held off while it is 0
//   x, y, color         registered pixel write data (valid with pixel_valid)
//   pixel_valid         pixel write strobe
//   busy                high in every state except idle
//   done                one-cycle pulse after the last pixel of a line
//   state_dbg           current FSM state, for debug and checkers
//
// Handshake: a request is accepted on the rising edge where start=1 and busy=0;
// there is no back-pressure on the pixel stream, so every cycle with
// pixel_valid=1 is one completed framebuffer write.
module line_drawer #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic          color_in,
  input  logic          clear_done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          color,
  output logic          pixel_valid,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state_dbg
);
  // Coordinates are carried XW bits wide internally because a steep line
  // moves y values onto the x (major) axis. Differences need one extra bit
  // for the sign, and the error term one more for the transient err - dy.
  localparam int DW = XW + 1;
  localparam int EW = XW + 2;
  localparam logic [XW-1:0] ONE = XW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CLR = 3'd1,
    S_SETUP_A  = 3'd2,
    S_SETUP_B  = 3'd3,
    S_DRAW     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t state, state_n;

  logic [XW-1:0] lx0, ly0, lx1, ly1;   // latched request
  logic          lcolor;
  logic          steep;
  logic [XW-1:0] ax0, ay0, ax1, ay1;   // transformed: a = major, ascending
  logic [DW-1:0] dx, dy;
  logic          ystep_neg;
  logic [EW-1:0] err;
  logic [XW-1:0] cx, cy;

  // Setup A: steepness test and endpoint reordering
  logic [DW-1:0] sdx, sdy, adx, ady;
  logic          steep_c, swap_c;
  logic [XW-1:0] tx0, ty0, tx1, ty1;
  // Setup B: slope terms
  logic [DW-1:0] bdx, bdy_s, bdy;
  logic          yneg_c;
  // Draw: next Bresenham step
  logic [EW-1:0] err_sub, err_nx;
  logic          err_neg;
  logic [XW-1:0] cx_nx, cy_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start) state_n = S_WAIT_CLR;
      S_WAIT_CLR: if (clear_done) state_n = S_SETUP_A;
      S_SETUP_A:  state_n = S_SETUP_B;
      S_SETUP_B:  state_n = S_DRAW;
      S_DRAW:     if (cx == ax1) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_comb begin
    sdx     = {1'b0, lx1} - {1'b0, lx0};
    sdy     = {1'b0, ly1} - {1'b0, ly0};
    adx     = sdx[DW-1] ? -sdx : sdx;
    ady     = sdy[DW-1] ? -sdy : sdy;
    steep_c = (ady > adx);
    tx0     = steep_c ? ly0 : lx0;
    ty0     = steep_c ? lx0 : ly0;
    tx1     = steep_c ? ly1 : lx1;
    ty1     = steep_c ? lx1 : ly1;
    swap_c  = (tx0 > tx1);

    bdx     = {1'b0, ax1} - {1'b0, ax0};
    bdy_s   = {1'b0, ay1} - {1'b0, ay0};
    bdy     = bdy_s[DW-1] ? -bdy_s : bdy_s;
    yneg_c  = !(ay0 < ay1);

    // err stays in [0, dx) between steps, so one conditional add of dx
    // after subtracting dy is enough to renormalise it.
    err_sub = err - {1'b0, dy};
    err_neg = err_sub[EW-1];
    err_nx  = err_neg ? (err_sub + {1'b0, dx}) : err_sub;
    cy_nx   = cy;
    if (err_neg) cy_nx = ystep_neg ? (cy - ONE) : (cy + ONE);
    cx_nx   = cx + ONE;
  end

  // Pixel outputs are registered: the edge that enters DRAW loads the first
  // pixel, and each DRAW edge loads the next one, so pixel_valid is high for
  // exactly the cycles spent in DRAW.
  always_ff @(posedge clk) begin
    if (reset) begin
      lx0 <= '0; ly0 <= '0; lx1 <= '0; ly1 <= '0; lcolor <= 1'b0;
      steep <= 1'b0;
      ax0 <= '0; ay0 <= '0; ax1 <= '0; ay1 <= '0;
      dx <= '0; dy <= '0; ystep_neg <= 1'b0; err <= '0;
      cx <= '0; cy <= '0;
      x <= '0; y <= '0; color <= 1'b0; pixel_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lx0    <= x0;
            ly0    <= XW'(y0);
            lx1    <= x1;
            ly1    <= XW'(y1);
            lcolor <= color_in;
          end
        end
        S_SETUP_A: begin
          steep <= steep_c;
          ax0   <= swap_c ? tx1 : tx0;
          ay0   <= swap_c ? ty1 : ty0;
          ax1   <= swap_c ? tx0 : tx1;
          ay1   <= swap_c ? ty0 : ty1;
        end
        S_SETUP_B: begin
          dx          <= bdx;
          dy          <= bdy;
          ystep_neg   <= yneg_c;
          err         <= {2'b00, bdx[DW-1:1]};
          cx          <= ax0;
          cy          <= ay0;
          x           <= steep ? ay0 : ax0;
          y           <= YW'(steep ? ax0 : ay0);
          color       <= lcolor;
          pixel_valid <= 1'b1;
        end
        S_DRAW: begin
          if (cx == ax1) begin
            pixel_valid <= 1'b0;
          end else begin
            err <= err_nx;
            cx  <= cx_nx;
            cy  <= cy_nx;
            x   <= steep ? cy_nx : cx_nx;
            y   <= YW'(steep ? cx_nx : cy_nx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_drawer.sv
// Self-checking bench for line_drawer. Expected pixels come from a closed-form
// Bresenham model: for step i along the major axis, the minor offset is
// ceil((i*dmin - floor(dmaj/2)) / dmaj), clamped at zero.
module tb_line_drawer;
  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic          color_in = 1'b0;
  logic          clear_done = 1'b1;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          color, pixel_valid, busy, done;
  logic [2:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [XW+YW-1:0] exp_q[$];

  line_drawer #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .color_in(color_in), .clear_done(clear_done),
    .x(x), .y(y), .color(color), .pixel_valid(pixel_valid),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // reference model: fills exp_q with the pixels of one line in draw order
  task automatic build_expected(input int ex0, input int ey0, input int ex1, input int ey1);
    int p0, q0, p1, q1, t, dmaj, dmin, h, num, k, sgn;
    bit st;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    exp_q.delete();
    st = iabs(ey1 - ey0) > iabs(ex1 - ex0);
    if (st) begin p0 = ey0; q0 = ex0; p1 = ey1; q1 = ex1; end
    else    begin p0 = ex0; q0 = ey0; p1 = ex1; q1 = ey1; end
    if (p0 > p1) begin
      t = p0; p0 = p1; p1 = t;
      t = q0; q0 = q1; q1 = t;
    end
    dmaj = p1 - p0;
    dmin = iabs(q1 - q0);
    sgn  = (q1 > q0) ? 1 : -1;
    h    = dmaj / 2;
    for (int i = 0; i <= dmaj; i++) begin
      num = i * dmin - h;
      k   = (num <= 0) ? 0 : (num + dmaj - 1) / dmaj;
      if (st) begin px = XW'(q0 + sgn * k); py = YW'(p0 + i); end
      else    begin px = XW'(p0 + i);       py = YW'(q0 + sgn * k); end
      exp_q.push_back({px, py});
    end
  endtask

  // driver + scoreboard for one request; called #1 after a rising edge
  task automatic run_line(input int lx0, input int ly0, input int lx1, input int ly1,
                          input bit c, input int clr_delay, input bit poke, input string name);
    int edges, cnt, exp_n;
    logic [XW+YW-1:0] e;
    build_expected(lx0, ly0, lx1, ly1);
    exp_n = exp_q.size();
    clear_done = (clr_delay == 0);
    x0 = lx0[XW-1:0]; y0 = ly0[YW-1:0]; x1 = lx1[XW-1:0]; y1 = ly1[YW-1:0];
    color_in = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // endpoints must already be latched
    x0 = XW'($urandom_range(0, 639)); x1 = XW'($urandom_range(0, 639));
    y0 = YW'($urandom_range(0, 479)); y1 = YW'($urandom_range(0, 479));
    color_in = ~c;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end
    edges = 0;
    while (pixel_valid !== 1'b1 && edges < clr_delay + 20) begin
      if (edges == clr_delay) clear_done = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    n_vec++;
    if (edges != clr_delay + 3) begin
      n_err++; $display("FAIL %s first_pixel_latency: got %0d edges want %0d", name, edges, clr_delay + 3);
    end
    cnt = 0;
    while (pixel_valid === 1'b1 && cnt < 2000) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL %s extra_pixel: got (%0d,%0d) want none", name, x, y);
      end else begin
        e = exp_q.pop_front();
        if ({x, y} !== e) begin
          n_err++;
          $display("FAIL %s pixel %0d: got (%0d,%0d) want (%0d,%0d)",
                   name, cnt, x, y, e[XW+YW-1:YW], e[YW-1:0]);
        end
      end
      n_vec++;
      if (color !== c || busy !== 1'b1 || done !== 1'b0) begin
        n_err++; $display("FAIL %s pixel_flags %0d: got color=%b busy=%b done=%b want %b 1 0",
                          name, cnt, color, busy, done, c);
      end
      if (poke && cnt == 4) begin
        start = 1'b1;
        x0 = 10'd7; y0 = 9'd7; x1 = 10'd8; y1 = 9'd8;
      end else begin
        start = 1'b0;
      end
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_vec++;
    if (cnt != exp_n) begin
      n_err++; $display("FAIL %s pixel_count: got %0d want %0d", name, cnt, exp_n);
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || pixel_valid !== 1'b0) begin
      n_err++; $display("FAIL %s done_cycle: got done=%b busy=%b pv=%b want 1 1 0", name, done, busy, pixel_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
      n_err++; $display("FAIL %s idle_after_done: got done=%b busy=%b pv=%b want 0 0 0", name, done, busy, pixel_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++;
    if ({x, y, color, pixel_valid, busy, done} !== '0) begin
      n_err++; $display("FAIL reset_state: got x=%0d y=%0d c=%b pv=%b busy=%b done=%b want all 0",
                        x, y, color, pixel_valid, busy, done);
    end
  endtask

  task automatic test_horizontal();
    run_line(10, 20, 15, 20, 1'b1, 0, 1'b0, "horizontal");
  endtask

  task automatic test_steep();
    logic [XW+YW-1:0] first, last;
    build_expected(0, 0, 2, 5);
    first = exp_q[0];
    last  = exp_q[exp_q.size() - 1];
    n_vec++;
    if (first !== {10'd0, 9'd0} || last !== {10'd2, 9'd5}) begin
      n_err++; $display("FAIL steep_model_ends: got %h %h want (0,0) (2,5)", first, last);
    end
    run_line(0, 0, 2, 5, 1'b0, 0, 1'b0, "steep");
  endtask

  task automatic test_reversed();
    run_line(15, 20, 10, 17, 1'b1, 0, 1'b0, "reversed");
  endtask

  task automatic test_clear_gating_point();
    run_line(5, 5, 5, 5, 1'b1, 100, 1'b0, "gated_point");
  endtask

  task automatic test_reset_midline();
    int edges;
    bit bad;
    logic [XW+YW-1:0] e;
    build_expected(0, 0, 639, 479);
    clear_done = 1'b1;
    x0 = '0; y0 = '0; x1 = 10'd639; y1 = 9'd479; color_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (pixel_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (pixel_valid !== 1'b1 || {x, y} !== e) begin
        n_err++; $display("FAIL abort_line pixel %0d: got pv=%b (%0d,%0d) want (%0d,%0d)",
                          i, pixel_valid, x, y, e[XW+YW-1:YW], e[YW-1:0]);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if ({x, y, color, pixel_valid, busy, done} !== '0) begin
      n_err++; $display("FAIL midline_reset: got x=%0d y=%0d c=%b pv=%b busy=%b done=%b want all 0",
                        x, y, color, pixel_valid, busy, done);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pixel_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL after_abort_quiet: got activity want none");
    end
    run_line(0, 0, 639, 479, 1'b1, 0, 1'b1, "full_line_poke");
  endtask

  task automatic test_back_to_back();
    int ax0, ay0, ax1, ay1;
    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0) begin
        ax0 = $urandom_range(0, 639); ax1 = $urandom_range(0, 639);
        ay0 = $urandom_range(0, 479); ay1 = $urandom_range(0, 479);
      end else begin
        ax0 = $urandom_range(300, 320); ax1 = $urandom_range(300, 320);
        ay0 = $urandom_range(200, 220); ay1 = $urandom_range(200, 220);
      end
      run_line(ax0, ay0, ax1, ay1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_reversed();
    test_clear_gating_point();
    test_reset_midline();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
